up_mem_arbiter: RTL

//  Shares the single-port 32x8 program/data RAM between the CPU control unit and a host

---
 rtl/up_mem_arbiter_pkg.sv | 17 +
 rtl/up_mem_arbiter_if.sv | 46 ++++
 rtl/up_mem_arbiter_rd_tag.sv | 49 ++++
 rtl/up_mem_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/up_mem_arbiter_pkg.sv
// Shared types for the program/data RAM arbiter: FSM state encoding and
// the owner tag carried alongside each granted read.
package up_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_HOST = 2'd2,
      ST_LOCK = 2'd3
   } state_e;

   typedef enum logic {
      OWNER_CPU  = 1'b0,
      OWNER_HOST = 1'b1
   } owner_e;

endpackage

// File: rtl/up_mem_arbiter_if.sv
// Bus bundle between the CPU control unit, the host load/debug port and the
// RAM macro. The arbiter takes the slave view; the surroundings take master.
interface up_mem_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   // CPU side
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_stall;
   logic          cpu_rvalid;
   // Host side
   logic          host_req;
   logic          host_we;
   logic          host_lock;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic          host_rvalid;
   // Shared read return
   logic [DW-1:0] rdata;
   // RAM macro side
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  host_req, host_we, host_lock, host_addr, host_wdata,
      input  mem_rdata,
      output cpu_stall, cpu_rvalid, host_gnt, host_rvalid, rdata,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output host_req, host_we, host_lock, host_addr, host_wdata,
      output mem_rdata,
      input  cpu_stall, cpu_rvalid, host_gnt, host_rvalid, rdata,
      input  mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/up_mem_arbiter_rd_tag.sv
// One-deep read-return pipeline: remembers who issued the read granted last
// cycle, raises that owner's rvalid while the sync RAM presents the word, and
// keeps the last returned word on rdata between reads.
module up_arb_rd_tag #(
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          cpu_rd_i,
   input  logic          host_rd_i,
   input  logic [DW-1:0] mem_rdata_i,
   output logic          cpu_rvalid_o,
   output logic          host_rvalid_o,
   output logic [DW-1:0] rdata_o
);
   import up_pkg::*;

   logic          vld_q;
   owner_e        owner_q;
   logic [DW-1:0] hold_q;

   // Tag the read issued this cycle with its owner for the return cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      if (!rst_n_i) begin
         vld_q   <= 1'b0;
         owner_q <= OWNER_CPU;
      end else begin
         vld_q   <= cpu_rd_i | host_rd_i;
         owner_q <= host_rd_i ? OWNER_HOST : OWNER_CPU;
      end
   end

   // Capture each returned word so rdata holds it after the return cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: this is a single data register, not a memory, so it is reset to
      // keep rdata at zero out of reset.
      if (!rst_n_i) begin
         hold_q <= '0;
      end else if (vld_q) begin
         hold_q <= mem_rdata_i;
      end
   end

   assign cpu_rvalid_o  = vld_q & (owner_q == OWNER_CPU);
   assign host_rvalid_o = vld_q & (owner_q == OWNER_HOST);
   assign rdata_o       = vld_q ? mem_rdata_i : hold_q;

endmodule

// File: rtl/up_mem_arbiter.sv
// Single-port RAM arbiter between the CPU control unit and the host port.
// One grant per cycle; host bursts are bounded while the CPU waits, the host
// may lock the RAM for program loading, and reads return one cycle later.
module up_mem_arbiter #(
   parameter int AW         = 5,
   parameter int DW         = 8,
   parameter int HOST_BURST = 4
) (
   input  logic           CLOCK,
   input  logic           RESET_N,
   up_mem_arbiter_if.slave bus
);
   import up_pkg::*;

   localparam int            CW        = $clog2(HOST_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(HOST_BURST);

   state_e        state_q, state_d;
   owner_e        last_q, last_d;
   logic [CW-1:0] burst_q, burst_d;
   logic          cpu_win, host_win;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;
   logic          win_we;

   // Pick this cycle's winner and the next FSM state, burst count and last owner.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      cpu_win  = 1'b0;
      host_win = 1'b0;
      state_d  = ST_IDLE;
      last_d   = last_q;
      burst_d  = burst_q;

      // Holding reset low blocks every grant so the RAM sees no access.
      if (RESET_N) begin
         if (state_q == ST_LOCK) begin
            host_win = bus.host_req;
         end else if (bus.cpu_req && bus.host_req) begin
            if (state_q == ST_HOST) host_win = (burst_q < BURST_MAX);
            else                    host_win = (last_q == OWNER_CPU);
            cpu_win = ~host_win;
         end else begin
            host_win = bus.host_req;
            cpu_win  = bus.cpu_req;
         end
      end

      if (state_q == ST_LOCK) state_d = bus.host_lock ? ST_LOCK : ST_IDLE;
      else if (host_win)      state_d = bus.host_lock ? ST_LOCK : ST_HOST;
      else if (cpu_win)       state_d = ST_CPU;

      if (host_win)     last_d = OWNER_HOST;
      else if (cpu_win) last_d = OWNER_CPU;

      if (cpu_win || !bus.cpu_req)            burst_d = '0;
      else if (host_win && burst_q < BURST_MAX) burst_d = burst_q + CW'(1);
   end

   // Advance FSM, last owner and burst counter.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         last_q  <= OWNER_CPU;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   // Route the winner onto the RAM port; no grant leaves the port quiet.
   always_comb begin
      win_addr  = '0;
      win_wdata = '0;
      win_we    = 1'b0;
      if (host_win) begin
         win_addr  = bus.host_addr;
         win_wdata = bus.host_wdata;
         win_we    = bus.host_we;
      end else if (cpu_win) begin
         win_addr  = bus.cpu_addr;
         win_wdata = bus.cpu_wdata;
         win_we    = bus.cpu_we;
      end
   end

   assign bus.mem_addr  = win_addr;
   assign bus.mem_wdata = win_wdata;
   assign bus.mem_we    = win_we;
   assign bus.host_gnt  = host_win;
   assign bus.cpu_stall = RESET_N & bus.cpu_req & ~cpu_win;

   up_arb_rd_tag #(
      .DW(DW)
   ) u_rd_tag (
      .clk_i        (CLOCK),
      .rst_n_i      (RESET_N),
      .cpu_rd_i     (cpu_win & ~bus.cpu_we),
      .host_rd_i    (host_win & ~bus.host_we),
      .mem_rdata_i  (bus.mem_rdata),
      .cpu_rvalid_o (bus.cpu_rvalid),
      .host_rvalid_o(bus.host_rvalid),
      .rdata_o      (bus.rdata)
   );

endmodule
